serial_deframer: RTL and testbench
==================================

# serial_deframer

Receive-side companion to the team's shift register: it consumes a start/stop-framed serial bit stream, as produced by a shift register's serial output, and rebuilds WIDTH-bit words. Bits are sampled on a one-cycle bit strobe. Each completed word is held in a single output buffer and handed downstream over a valid/ready handshake. Framing errors and buffer overruns are flagged with one-cycle pulses.

## Interface
- WIDTH, 8, data bits per frame (≥2)
- SHIFT_DIR, 0, bit order on the line: 0 = LSB first (matches right-shift serial output), 1 = MSB first
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset: one clock; reset is synchronous and active-high
- bit_en  input  1  bit strobe; serial_in is sampled only in cycles where bit_en=1
- serial_in  input  1  serial line, idle level 1
- data_out  output  WIDTH  received word; stable while data_valid=1
- data_valid  output  1  data_out holds an unconsumed word
- data_ready  input  1  downstream accepts; transfer when data_valid & data_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  one-cycle pulse: word completed while buffer full and not draining
- busy  output  1  high whenever state ≠ IDLE

## Operation
- Frame on line: start bit (0), WIDTH data bits, stop bit (1). One bit per bit_en strobe.
- States: IDLE, DATA, STOP, BREAK.
- IDLE: on bit_en & serial_in=0 → DATA, bit counter cleared to 0. bit_en & serial_in=1 → stay.
- DATA: each bit_en captures serial_in into the assembly register and increments the counter.
  - SHIFT_DIR=0: first data bit → bit 0, last → bit WIDTH-1.
  - SHIFT_DIR=1: first data bit → bit WIDTH-1.
  - After the WIDTH-th capture (counter = WIDTH-1 at strobe) → STOP.
- STOP: on bit_en:
  - serial_in=1 → word complete. Offer it to the output buffer and go to IDLE.
  - serial_in=0 → frame_err pulse. Word discarded, output buffer untouched. → BREAK.
- BREAK: wait for bit_en & serial_in=1 → IDLE. A low line never restarts a frame from BREAK.
- Output buffer, on word completion:
  - Buffer empty, or data_valid & data_ready in the same cycle → load new word, data_valid=1.
  - Buffer full and data_ready=0 → old word kept, new word dropped, overrun pulse.
- data_valid clears the cycle after a transfer unless a new word loads in that same cycle.
- The counter is ceil(log2(WIDTH)) bits wide. It never wraps beyond WIDTH-1: it clears on the DATA entry.
- bit_en low: state, counter and assembly register hold. The handshake still operates every clk.
- rst in any state (mid-frame included) → IDLE on the next edge.
  - data_valid, frame_err, overrun and busy go to 0; counter, data_out and the assembly register go to 0.
  - Any partial frame is lost.

## Timing
- Reset values: data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
- State transitions take effect on the clk edge where bit_en=1 is sampled.
- busy rises the cycle after the start-bit strobe. It falls the cycle after the stop-bit strobe (valid stop) or the BREAK-exit strobe.
- data_valid rises the cycle after the stop-bit strobe: one clk of latency from the stop-bit sample.
- frame_err and overrun assert in the cycle after the stop-bit strobe, for exactly one clk.
- Back-to-back frames: a start bit on the strobe immediately after the stop-bit strobe is accepted, so there is no idle-bit requirement.
- data_ready may be high with data_valid=0; this has no effect.
- There is no combinational path from data_ready to data_valid or data_out.

## Test plan
- **Basic, LSB first:** WIDTH=8, SHIFT_DIR=0, bit_en every 4th clk, frame 0,(0xA5 LSB first),1, data_ready=1.
  - data_out=0xA5 and data_valid=1 one clk after the stop strobe.
  - Transfer occurs; busy 0 after.
- **MSB first:** SHIFT_DIR=1, send 0x3C MSB first → data_out=0x3C.
- **Framing error:** send 0x55 with stop bit 0, line held 0 for 3 strobes, then 1.
  - frame_err pulses one clk; data_valid stays 0.
  - busy stays high until the strobe sampling 1.
  - A following valid frame 0x12 → data_out=0x12.
- **Overrun / simultaneous:** data_ready=0, send 0x11 then 0x22 → data_out=0x11, overrun pulse on the 0x22 completion.
  - Repeat with data_ready=1 exactly in the 0x22 completion cycle → 0x11 transferred, then data_out=0x22, no overrun.
- **Back-to-back:** three frames 0x01, 0x80, 0xFF with no idle bits, data_ready=1 → three transfers in order.
- **Reset mid-frame:** assert rst after 4 data bits → all outputs 0, busy 0.
  - A fresh frame 0x5A after release is received correctly.

Source files
------------

// File: rtl/serial_deframer_if.sv
// Serial-line inputs and word-side valid/ready outputs of the serial deframer.
// The master modport is the deframer; the slave modport is the line driver and word consumer.
interface serial_deframer_if #(
    parameter int WIDTH = 8
);
    logic             bit_en;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    modport master (
        input  bit_en, serial_in, data_ready,
        output data_out, data_valid, frame_err, overrun, busy
    );

    modport slave (
        output bit_en, serial_in, data_ready,
        input  data_out, data_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/serial_deframer.sv
// Start/stop framed serial receiver. It rebuilds WIDTH-bit words and holds each one
// in a single-entry valid/ready output buffer.
module serial_deframer #(
    parameter int WIDTH     = 8,
    parameter bit SHIFT_DIR = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    serial_deframer_if.master bus
);
    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STOP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] asm_r;
    logic [WIDTH-1:0] data_out_r;
    logic             data_valid_r;
    logic             frame_err_r;
    logic             overrun_r;
    logic             busy_r;
    logic             start_s;
    logic             capture_s;
    logic             word_done_s;
    logic             frame_err_s;
    logic             load_s;
    logic             drain_s;
    logic             overrun_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; nothing advances without a bit strobe
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.bit_en && !bus.serial_in) state_nx_s = ST_DATA;
                else                              state_nx_s = ST_IDLE;
            end
            ST_DATA: begin
                if (bus.bit_en && (cnt_r == CNT_LAST)) state_nx_s = ST_STOP;
                else                                   state_nx_s = ST_DATA;
            end
            ST_STOP: begin
                if (bus.bit_en) state_nx_s = bus.serial_in ? ST_IDLE : ST_BREAK;
                else            state_nx_s = ST_STOP;
            end
            ST_BREAK: begin
                if (bus.bit_en && bus.serial_in) state_nx_s = ST_IDLE;
                else                             state_nx_s = ST_BREAK;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Per-state strobe qualifiers for the datapath and output buffer
    always_comb begin
        start_s     = 1'b0;
        capture_s   = 1'b0;
        word_done_s = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            ST_IDLE:  start_s   = bus.bit_en & ~bus.serial_in;
            ST_DATA:  capture_s = bus.bit_en;
            ST_STOP: begin
                word_done_s = bus.bit_en &  bus.serial_in;
                frame_err_s = bus.bit_en & ~bus.serial_in;
            end
            ST_BREAK: start_s   = 1'b0;
            default:  start_s   = 1'b0;
        endcase
    end

    // A full buffer still accepts a new word when it drains in the same cycle
    assign drain_s   = data_valid_r & bus.data_ready;
    assign load_s    = word_done_s & (~data_valid_r | bus.data_ready);
    assign overrun_s = word_done_s & data_valid_r & ~bus.data_ready;

    // Bit counter and assembly shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            asm_r <= {WIDTH{1'b0}};
        end else if (start_s) begin
            cnt_r <= {CW{1'b0}};
        end else if (capture_s) begin
            cnt_r <= (cnt_r == CNT_LAST) ? cnt_r : cnt_r + CW'(1);
            if (SHIFT_DIR) asm_r <= {asm_r[WIDTH-2:0], bus.serial_in};
            else           asm_r <= {bus.serial_in, asm_r[WIDTH-1:1]};
        end else begin
            cnt_r <= cnt_r;
            asm_r <= asm_r;
        end
    end

    // Output buffer, status pulses and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r   <= {WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            frame_err_r <= frame_err_s;
            overrun_r   <= overrun_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            if (load_s) begin
                data_out_r   <= asm_r;
                data_valid_r <= 1'b1;
            end else if (drain_s) begin
                data_valid_r <= 1'b0;
            end else begin
                data_valid_r <= data_valid_r;
            end
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.overrun    = overrun_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_serial_deframer.sv
// Bench for serial_deframer: an LSB-first and an MSB-first instance share one line,
// and both are compared every cycle against a frame-level reference model.
module tb_serial_deframer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_en = 1'b0;
    logic serial_in = 1'b1;
    logic data_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_policy = 0;
    int n_ferr_l = 0;
    int n_ovr_l = 0;
    logic [W-1:0] xq_l[$];
    logic [W-1:0] xq_m[$];

    // reference model: line mode, bits gathered so far, output buffer image
    int           m_mode = 0;
    bit           m_bits[$];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data[2] = '{8'h00, 8'h00};
    logic         m_ferr = 1'b0;
    logic         m_ovr = 1'b0;

    serial_deframer_if #(.WIDTH(W)) dif_l ();
    serial_deframer_if #(.WIDTH(W)) dif_m ();

    assign dif_l.bit_en = bit_en;
    assign dif_l.serial_in = serial_in;
    assign dif_l.data_ready = data_ready;
    assign dif_m.bit_en = bit_en;
    assign dif_m.serial_in = serial_in;
    assign dif_m.data_ready = data_ready;

    serial_deframer #(.WIDTH(W), .SHIFT_DIR(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(dif_l));
    serial_deframer #(.WIDTH(W), .SHIFT_DIR(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(dif_m));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] bits_to_word(input bit msb);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb) w[W-1-i] = m_bits[i];
            else     w[i] = m_bits[i];
        end
        return w;
    endfunction

    task automatic model_step();
        bit done;
        done = 1'b0;
        m_ferr = 1'b0;
        m_ovr = 1'b0;
        if (rst) begin
            m_mode = 0;
            m_bits.delete();
            m_valid = 1'b0;
            m_data[0] = '0;
            m_data[1] = '0;
            return;
        end
        if (bit_en) begin
            case (m_mode)
                0: if (!serial_in) begin m_mode = 1; m_bits.delete(); end
                1: begin
                    m_bits.push_back(serial_in);
                    if (m_bits.size() == W) m_mode = 2;
                end
                2: if (serial_in) begin done = 1'b1; m_mode = 0; end
                   else begin m_ferr = 1'b1; m_mode = 3; end
                default: if (serial_in) m_mode = 0;
            endcase
        end
        if (done && (!m_valid || data_ready)) begin
            m_valid = 1'b1;
            m_data[0] = bits_to_word(1'b0);
            m_data[1] = bits_to_word(1'b1);
        end else if (done) begin
            m_ovr = 1'b1;
        end else if (m_valid && data_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cmp_one(input string tag, input logic v, input logic [W-1:0] dout,
                           input logic b, input logic fe, input logic ov, input int d);
        check_eq({tag, "_valid"}, v, m_valid);
        check_eq({tag, "_data"}, dout, m_data[d]);
        check_eq({tag, "_busy"}, b, (m_mode != 0));
        check_eq({tag, "_ferr"}, fe, m_ferr);
        check_eq({tag, "_ovr"}, ov, m_ovr);
    endtask

    task automatic tick();
        if (!rst && dif_l.data_valid && data_ready) xq_l.push_back(dif_l.data_out);
        if (!rst && dif_m.data_valid && data_ready) xq_m.push_back(dif_m.data_out);
        @(posedge clk);
        model_step();
        #1;
        cmp_one("lsb", dif_l.data_valid, dif_l.data_out, dif_l.busy, dif_l.frame_err, dif_l.overrun, 0);
        cmp_one("msb", dif_m.data_valid, dif_m.data_out, dif_m.busy, dif_m.frame_err, dif_m.overrun, 1);
        if (dif_l.frame_err) n_ferr_l++;
        if (dif_l.overrun) n_ovr_l++;
    endtask

    task automatic set_ready(input int f);
        if (f >= 0)               data_ready = f[0];
        else if (rdy_policy == 2) data_ready = 1'($urandom_range(0, 1));
        else                      data_ready = rdy_policy[0];
    endtask

    // one strobe, then gap-1 quiet cycles with a noisy line
    task automatic strobe(input bit b, input int gap, input int rdy_force);
        bit_en = 1'b1;
        serial_in = b;
        set_ready(rdy_force);
        tick();
        bit_en = 1'b0;
        for (int k = 1; k < gap; k++) begin
            serial_in = 1'($urandom_range(0, 1));
            set_ready(-1);
            tick();
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit msb, input bit stop_b,
                              input int gap, input int stop_rdy);
        strobe(1'b0, gap, -1);
        for (int i = 0; i < W; i++) strobe(msb ? w[W-1-i] : w[i], gap, -1);
        strobe(stop_b, gap, stop_rdy);
    endtask

    task automatic idle(input int n);
        bit_en = 1'b0;
        for (int k = 0; k < n; k++) begin
            set_ready(-1);
            tick();
        end
    endtask

    initial begin
        // reset
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", dif_l.data_valid, 1'b0);
        check_eq("rst_busy", dif_l.busy, 1'b0);
        check_eq("rst_dout", dif_l.data_out, 8'h00);

        // basic LSB first, strobe every 4th clk
        rdy_policy = 1;
        send_frame(8'hA5, 1'b0, 1'b1, 4, -1);
        idle(2);
        check_eq("a5_count", xq_l.size(), 1);
        check_eq("a5_word", xq_l[0], 8'hA5);
        check_eq("a5_busy", dif_l.busy, 1'b0);

        // MSB first
        xq_m.delete();
        send_frame(8'h3C, 1'b1, 1'b1, 3, -1);
        idle(2);
        check_eq("3c_word", xq_m[0], 8'h3C);

        // framing error, line held low, then recovery
        xq_l.delete();
        n_ferr_l = 0;
        send_frame(8'h55, 1'b0, 1'b0, 2, -1);
        for (int i = 0; i < 3; i++) begin
            strobe(1'b0, 2, -1);
            check_eq("brk_busy", dif_l.busy, 1'b1);
        end
        strobe(1'b1, 2, -1);
        check_eq("brk_exit", dif_l.busy, 1'b0);
        check_eq("ferr_pulses", n_ferr_l, 1);
        check_eq("ferr_noword", xq_l.size(), 0);
        send_frame(8'h12, 1'b0, 1'b1, 2, -1);
        idle(2);
        check_eq("12_word", xq_l[0], 8'h12);

        // overrun with consumer stalled
        xq_l.delete();
        n_ovr_l = 0;
        rdy_policy = 0;
        send_frame(8'h11, 1'b0, 1'b1, 2, -1);
        send_frame(8'h22, 1'b0, 1'b1, 2, -1);
        check_eq("ovr_pulses", n_ovr_l, 1);
        check_eq("ovr_keep", dif_l.data_out, 8'h11);
        data_ready = 1'b1;
        tick();
        idle(1);
        check_eq("ovr_drain", xq_l[0], 8'h11);
        check_eq("ovr_empty", dif_l.data_valid, 1'b0);

        // drain in the same cycle the next word completes
        xq_l.delete();
        n_ovr_l = 0;
        send_frame(8'h11, 1'b0, 1'b1, 2, -1);
        send_frame(8'h22, 1'b0, 1'b1, 2, 1);
        check_eq("sim_xfer", xq_l[0], 8'h11);
        check_eq("sim_dout", dif_l.data_out, 8'h22);
        check_eq("sim_noovr", n_ovr_l, 0);
        rdy_policy = 1;
        idle(2);

        // back-to-back frames, strobe every clk
        xq_l.delete();
        send_frame(8'h01, 1'b0, 1'b1, 1, -1);
        send_frame(8'h80, 1'b0, 1'b1, 1, -1);
        send_frame(8'hFF, 1'b0, 1'b1, 1, -1);
        idle(2);
        check_eq("b2b_count", xq_l.size(), 3);
        check_eq("b2b_0", xq_l[0], 8'h01);
        check_eq("b2b_1", xq_l[1], 8'h80);
        check_eq("b2b_2", xq_l[2], 8'hFF);

        // reset mid-frame
        strobe(1'b0, 2, -1);
        for (int i = 0; i < 4; i++) strobe(1'b1, 2, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_busy", dif_l.busy, 1'b0);
        check_eq("mrst_valid", dif_l.data_valid, 1'b0);
        check_eq("mrst_dout", dif_l.data_out, 8'h00);
        xq_l.delete();
        send_frame(8'h5A, 1'b0, 1'b1, 2, -1);
        idle(2);
        check_eq("5a_word", xq_l[0], 8'h5A);

        // randomized traffic against the model
        rdy_policy = 2;
        for (int f = 0; f < 150; f++) begin
            int  gap;
            bit  bad;
            gap = $urandom_range(1, 3);
            bad = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 24) == 0) begin
                strobe(1'b0, gap, -1);
                for (int i = 0; i < $urandom_range(0, 6); i++) strobe(1'($urandom_range(0, 1)), gap, -1);
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            for (int i = 0; i < $urandom_range(0, 2); i++) strobe(1'b1, gap, -1);
            send_frame(W'($urandom), 1'b0, !bad, gap, -1);
            if (bad) begin
                for (int i = 0; i < $urandom_range(0, 2); i++) strobe(1'b0, gap, -1);
                strobe(1'b1, gap, -1);
            end
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
